// File: rtl/scc_8lc_encode_arbiter.sv
// scc_8lc_encode_arbiter: two-port arbiter in front of a shared SCC_8LC encoder
// (64b message -> 72b codeword). Port 0 (demand write) has fixed priority;
// port 1 (scrub write-back) is forced through after STARVE_LIMIT blocked cycles.
// The encoded result is buffered in a 2-entry output queue whose head drives cw_*.
// Check bits: CRC-8, polynomial x^8+x^4+x^3+x^2+1 (0x1D), MSB-first, zero init.
// Optional build macro: SCC_ENC_ARB_STATS_EN adds 32-bit grant/force counters.
module scc_8lc_encode_arbiter #(
  parameter int unsigned TAG_W        = 8,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_msg,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_msg,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             cw_valid,
  input  logic             cw_ready,
  output logic [71:0]      cw_data,
  output logic [TAG_W-1:0] cw_tag,
  output logic             cw_src
`ifdef SCC_ENC_ARB_STATS_EN
  ,
  output logic [31:0]      stat_grant0,
  output logic [31:0]      stat_grant1,
  output logic [31:0]      stat_force
`endif
);

  localparam int unsigned MSG_W = 64;
  localparam int unsigned CHK_W = 8;
  localparam int unsigned CW_W  = MSG_W + CHK_W;
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CHK_W-1:0] CHK_POLY = 8'h1D;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_t;

  q_state_t           state, state_next;
  logic               load_head, load_tail, head_from_tail;
  logic [CNT_W-1:0]   starve_cnt;
  logic               space, force1, grant0, grant1, push, pop;
  logic [MSG_W-1:0]   sel_msg;
  logic [TAG_W-1:0]   sel_tag;
  logic               sel_src;
  logic [CW_W-1:0]    enc_data;
  logic [CW_W-1:0]    tail_data;
  logic [TAG_W-1:0]   tail_tag;
  logic               tail_src;

  // SCC_8LC check bits: remainder of msg(x)*x^8 divided by the check polynomial
  function automatic logic [CHK_W-1:0] scc_check(input logic [MSG_W-1:0] msg);
    logic [CHK_W-1:0] crc;
    logic             fb;
    crc = '0;
    for (int i = MSG_W - 1; i >= 0; i--) begin
      fb  = crc[CHK_W-1] ^ msg[i];
      crc = {crc[CHK_W-2:0], 1'b0} ^ ({CHK_W{fb}} & CHK_POLY);
    end
    return crc;
  endfunction

  // Readiness depends on queue state, starvation and port-0 valid only; no path from cw_ready
  always_comb begin
    space      = (state != Q_FULL);
    force1     = (starve_cnt == CNT_W'(STARVE_LIMIT));
    req0_ready = ~rst & space & ~force1;
    req1_ready = ~rst & space & (force1 | ~req0_valid);
    grant0     = req0_valid & req0_ready;
    grant1     = req1_valid & req1_ready;
    push       = grant0 | grant1;
    pop        = cw_valid & cw_ready;
  end

  // Winner mux feeding the shared encoder; result is written straight into the queue
  always_comb begin
    sel_msg  = grant1 ? req1_msg : req0_msg;
    sel_tag  = grant1 ? req1_tag : req0_tag;
    sel_src  = grant1;
    enc_data = {sel_msg, scc_check(sel_msg)};
  end

  // Queue state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= Q_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Queue next-state and entry-move controls
  always_comb begin
    state_next     = state;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    case (state)
      Q_EMPTY: begin
        if (push) begin
          state_next = Q_ONE;
          load_head  = 1'b1;
        end
      end
      Q_ONE: begin
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_next = Q_FULL;
          load_tail  = 1'b1;
        end else if (pop) begin
          state_next = Q_EMPTY;
        end
      end
      Q_FULL: begin
        if (pop) begin
          state_next     = Q_ONE;
          head_from_tail = 1'b1;
        end
      end
      default: begin
        state_next = Q_EMPTY;
      end
    endcase
  end

  // Head entry (drives cw_*) and tail entry registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_valid  <= 1'b0;
      cw_data   <= '0;
      cw_tag    <= '0;
      cw_src    <= 1'b0;
      tail_data <= '0;
      tail_tag  <= '0;
      tail_src  <= 1'b0;
    end else begin
      cw_valid <= (state_next != Q_EMPTY);
      if (load_head) begin
        cw_data <= enc_data;
        cw_tag  <= sel_tag;
        cw_src  <= sel_src;
      end else if (head_from_tail) begin
        cw_data <= tail_data;
        cw_tag  <= tail_tag;
        cw_src  <= tail_src;
      end
      if (load_tail) begin
        tail_data <= enc_data;
        tail_tag  <= sel_tag;
        tail_src  <= sel_src;
      end
    end
  end

  // Starvation counter: counts cycles port 1 loses to port 0 while there is space
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!req1_valid || grant1) begin
      starve_cnt <= '0;
    end else if (space && !force1) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

`ifdef SCC_ENC_ARB_STATS_EN
  // Grant statistics, free-running and wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_force  <= '0;
    end else begin
      if (grant0) stat_grant0 <= stat_grant0 + 32'd1;
      if (grant1) stat_grant1 <= stat_grant1 + 32'd1;
      if (grant1 && force1) stat_force <= stat_force + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scc_8lc_encode_arbiter.sv
// Bench for scc_8lc_encode_arbiter: scoreboard of expected codewords fed by a
// queue-occupancy/starvation reference model; a monitor pops on each DUT pop.
module tb_scc_8lc_encode_arbiter;
  localparam int unsigned TAG_W        = 8;
  localparam int unsigned STARVE_LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0]      req0_msg, req1_msg;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             cw_valid, cw_ready, cw_src;
  logic [71:0]      cw_data;
  logic [TAG_W-1:0] cw_tag;
`ifdef SCC_ENC_ARB_STATS_EN
  logic [31:0]      stat_grant0, stat_grant1, stat_force;
`endif

  always #5 clk = ~clk;

  scc_8lc_encode_arbiter #(.TAG_W(TAG_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_msg(req0_msg), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_msg(req1_msg), .req1_tag(req1_tag),
    .cw_valid(cw_valid), .cw_ready(cw_ready), .cw_data(cw_data), .cw_tag(cw_tag), .cw_src(cw_src)
`ifdef SCC_ENC_ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_force(stat_force)
`endif
  );

  typedef struct packed {
    logic [71:0]      data;
    logic [TAG_W-1:0] tag;
    logic             src;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // reference model state
  int   m_count, m_starve, m_g0, m_g1, m_force;
  int   dut_g1_cnt;
  logic             p0_v, p1_v;
  logic [63:0]      p0_m, p1_m;
  logic [TAG_W-1:0] p0_t, p1_t;

  // codeword by polynomial long division of {msg, 8'h00} by 0x11D
  function automatic logic [71:0] ref_cw(input logic [63:0] m);
    logic [71:0] r;
    logic [71:0] poly;
    r    = {m, 8'h00};
    poly = 72'h11D;
    for (int b = 71; b >= 8; b--)
      if (r[b]) r = r ^ (poly << (b - 8));
    return {m, r[7:0]};
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_starve = 0; m_g0 = 0; m_g1 = 0; m_force = 0;
    p0_v = 1'b0; p1_v = 1'b0;
    sb.delete();
  endtask

  // one clock of stimulus plus reference-model update
  task automatic step(input logic rdy);
    bit space, frc, er0, er1, g0, g1, pp;
    @(negedge clk);
    req0_valid = p0_v; req0_msg = p0_m; req0_tag = p0_t;
    req1_valid = p1_v; req1_msg = p1_m; req1_tag = p1_t;
    cw_ready   = rdy;
    #1;
    space = (m_count < 2);
    frc   = (m_starve == STARVE_LIMIT);
    er0   = space && !frc;
    er1   = space && (frc || !p0_v);
    check("req0_ready", 72'(req0_ready), 72'(er0));
    check("req1_ready", 72'(req1_ready), 72'(er1));
    check("cw_valid", 72'(cw_valid), 72'(m_count > 0));
    if (req1_valid && req1_ready) dut_g1_cnt++;
    g0 = p0_v && er0;
    g1 = p1_v && er1;
    if (g0) begin sb.push_back('{ref_cw(p0_m), p0_t, 1'b0}); m_g0++; end
    if (g1) begin sb.push_back('{ref_cw(p1_m), p1_t, 1'b1}); m_g1++; if (frc) m_force++; end
    pp = (m_count > 0) && rdy;
    m_count = m_count + int'(g0 || g1) - int'(pp);
    if (!p1_v || g1) m_starve = 0;
    else if (space && m_starve < STARVE_LIMIT) m_starve++;
    if (g0) p0_v = 1'b0;
    if (g1) p1_v = 1'b0;
  endtask

  task automatic new0(input logic [63:0] m, input logic [TAG_W-1:0] t);
    p0_v = 1'b1; p0_m = m; p0_t = t;
  endtask

  task automatic new1(input logic [63:0] m, input logic [TAG_W-1:0] t);
    p1_v = 1'b1; p1_m = m; p1_t = t;
  endtask

  function automatic logic [63:0] rmsg();
    return {$urandom, $urandom};
  endfunction

  // monitor: compare head entry against scoreboard whenever the DUT pops
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && cw_valid && cw_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop_empty: got cw_data %h expected no entry", cw_data);
        end else begin
          e = sb.pop_front();
          check("cw_data", cw_data, e.data);
          check("cw_tag", 72'(cw_tag), 72'(e.tag));
          check("cw_src", 72'(cw_src), 72'(e.src));
        end
      end
    end
  end

  initial begin
    int win_start;
`ifdef SCC_ENC_ARB_STATS_EN
    logic [31:0] f0;
`endif
    rst = 1'b1;
    req0_valid = 1'b0; req0_msg = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_msg = '0; req1_tag = '0;
    cw_ready = 1'b0;
    p0_m = '0; p0_t = '0; p1_m = '0; p1_t = '0;
    dut_g1_cnt = 0;
    model_reset();

    // reset state; readiness must stay low while rst is high
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("rst_req0_ready", 72'(req0_ready), 72'(0));
    check("rst_req1_ready", 72'(req1_ready), 72'(0));
    check("rst_cw_valid", 72'(cw_valid), 72'(0));
    check("rst_cw_data", cw_data, 72'h0);
    check("rst_cw_tag", 72'(cw_tag), 72'(0));
    check("rst_cw_src", 72'(cw_src), 72'(0));
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // zero message, then message 1 from each port
    new0(64'h0, 8'h00);           step(1'b1);
    new0(64'h1, 8'h5A);           step(1'b1);
    new1(64'h1, 8'h5A);           step(1'b1);
    step(1'b1); step(1'b1);

    // fill with cw_ready low: two accepted, third stalled until space returns
    for (int i = 0; i < 3; i++) begin
      if (!p0_v) new0(rmsg(), 8'(i + 1));
      step(1'b0);
    end
    for (int i = 0; i < 6; i++) step(1'b1);

    // both ports continuously valid: port 1 wins once per STARVE_LIMIT+1 grants
`ifdef SCC_ENC_ARB_STATS_EN
    f0 = stat_force;
`endif
    win_start = dut_g1_cnt;
    for (int i = 0; i < 5 * (STARVE_LIMIT + 1); i++) begin
      if (!p0_v) new0(rmsg(), 8'($urandom));
      if (!p1_v) new1(rmsg(), 8'($urandom));
      step(1'b1);
    end
    check("starve_port1_grants", 72'(dut_g1_cnt - win_start), 72'(5));
`ifdef SCC_ENC_ARB_STATS_EN
    #1;
    check("stat_force_delta", 72'(stat_force - f0), 72'(5));
`endif
    p0_v = 1'b0; p1_v = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1);

    // randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      if (!p0_v && ($urandom_range(0, 99) < 55)) new0(rmsg(), 8'($urandom));
      if (!p1_v && ($urandom_range(0, 99) < 45)) new1(rmsg(), 8'($urandom));
      step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    // fill the queue, then assert reset mid-transfer
    for (int i = 0; i < 12 && m_count < 2; i++) begin
      if (!p0_v) new0(rmsg(), 8'($urandom));
      step(1'b0);
    end
    check("full_before_rst", 72'(m_count), 72'(2));
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_cw_valid", 72'(cw_valid), 72'(0));
    check("async_rst_req0_ready", 72'(req0_ready), 72'(0));
    model_reset();
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1); step(1'b1);
    for (int i = 0; i < 60; i++) begin
      if (!p0_v && ($urandom_range(0, 1) == 1)) new0(rmsg(), 8'($urandom));
      if (!p1_v && ($urandom_range(0, 2) == 0)) new1(rmsg(), 8'($urandom));
      step(($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0);
    end

    // drain
    for (int i = 0; i < 20; i++) begin
      if (m_count == 0 && !p0_v && !p1_v) break;
      step(1'b1);
    end
    step(1'b1);
    check("scoreboard_empty", 72'(sb.size()), 72'(0));
`ifdef SCC_ENC_ARB_STATS_EN
    check("stat_grant0", 72'(stat_grant0), 72'(m_g0));
    check("stat_grant1", 72'(stat_grant1), 72'(m_g1));
    check("stat_force", 72'(stat_force), 72'(m_force));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
